sm_fv_pingpong_buffer: RTL and testbench

- Receives the big-FV-bank-to-small-FV-bank stream (sos/eos/A/FV_data) produced by the big feature-value bank controller for one replay iteration.
- Stores each streamed iteration into one half of a two-entry ping-pong line buffer while the other half serves random reads from the Edge PE side.
- Tracks fill/ready/release per half, so the upstream controller can stream the next iteration while the current one is consumed.

---
 rtl/sm_fv_pingpong_buffer.sv | 156 +++++++++++++++
 tb/tb_sm_fv_pingpong_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_fv_pingpong_buffer.sv
// Two-half ping-pong line buffer between the big FV bank stream and the
// Edge PE read side. One half fills from the sos/eos stream while the other
// half serves registered random reads until the consumer releases it.
module sm_fv_pingpong_buffer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sos,
  input  logic              in_eos,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              rd_release,
  output logic              buf_ready,
  output logic              can_accept,
  output logic [ADDR_W:0]   lines_stored,
  output logic              overflow_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {H_FREE, H_FILLING, H_FULL} half_st_t;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_st_t;

  half_st_t          half_q [2];
  half_st_t          half_d [2];
  logic [ADDR_W:0]   stored_q [2];
  logic [ADDR_W:0]   stored_d [2];
  wr_st_t            wst_q, wst_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              we;
  logic [ADDR_W:0]   cnt_n;

  logic [DATA_W-1:0] mem [2][DEPTH];

  assign buf_ready     = (half_q[rd_sel_q] == H_FULL);
  assign can_accept    = (half_q[wr_sel_q] == H_FREE) && (wst_q == W_IDLE);
  assign lines_stored  = buf_ready ? stored_q[rd_sel_q] : '0;
  assign overflow_err  = ovf_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;

  // Next-state for the write FSM, per-half states, read path and release.
  // Write decisions use pre-release half states; release and write never
  // touch the same half in one cycle (release needs FULL, writes need
  // FREE/FILLING), so both updates are applied independently.
  always_comb begin
    half_d     = half_q;
    stored_d   = stored_q;
    wst_d      = wst_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    we         = 1'b0;
    cnt_n      = cnt_q;

    if (rd_en && buf_ready) begin
      rd_data_d  = mem[rd_sel_q][rd_addr];
      rd_valid_d = 1'b1;
    end

    if (rd_release && buf_ready) begin
      half_d[rd_sel_q] = H_FREE;
      rd_sel_d         = ~rd_sel_q;
    end

    case (wst_q)
      W_IDLE: begin
        if (in_valid && in_sos) begin
          if (half_q[wr_sel_q] == H_FREE) begin
            we    = 1'b1;
            cnt_d = CNT_ONE;
            if (in_eos) begin
              half_d[wr_sel_q]   = H_FULL;
              stored_d[wr_sel_q] = CNT_ONE;
              wr_sel_d           = ~wr_sel_q;
            end else begin
              half_d[wr_sel_q] = H_FILLING;
              wst_d            = W_FILL;
            end
          end else begin
            ovf_d = 1'b1;
            if (!in_eos) wst_d = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          we = 1'b1;
          if (in_sos)                cnt_n = CNT_ONE;
          else if (cnt_q != CNT_MAX) cnt_n = cnt_q + 1'b1;
          cnt_d = cnt_n;
          if (in_eos) begin
            half_d[wr_sel_q]   = H_FULL;
            stored_d[wr_sel_q] = cnt_n;
            wr_sel_d           = ~wr_sel_q;
            wst_d              = W_IDLE;
          end
        end
      end
      W_DROP: begin
        if (in_valid && in_eos) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_q[0]   <= H_FREE;
      half_q[1]   <= H_FREE;
      stored_q[0] <= '0;
      stored_q[1] <= '0;
      wst_q       <= W_IDLE;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      half_q      <= half_d;
      stored_q    <= stored_d;
      wst_q       <= wst_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Line storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[wr_sel_q][in_addr] <= in_data;
  end

endmodule

// File: tb/tb_sm_fv_pingpong_buffer.sv
// Directed bench for sm_fv_pingpong_buffer. A queue-based model of completed
// buffers predicts every output each cycle; literal checks pin key values.
module tb_sm_fv_pingpong_buffer;
  localparam int DW = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_sos, in_eos;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          rd_release;
  logic          buf_ready, can_accept, overflow_err;
  logic [AW:0]   lines_stored;

  int n_cmp = 0;
  int n_bad = 0;

  sm_fv_pingpong_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sos(in_sos),
    .in_eos(in_eos), .in_addr(in_addr), .in_data(in_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .rd_release(rd_release), .buf_ready(buf_ready), .can_accept(can_accept),
    .lines_stored(lines_stored), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: FIFO of completed halves ----------------
  int unsigned   q_half[$];
  int unsigned   q_cnt[$];
  logic [DW-1:0] mm [2][64];
  bit            known [2][64];
  int            mode;      // 0 idle, 1 filling, 2 dropping
  int unsigned   wr_idx, fcnt, push_c, n_full;
  bit            m_ovf, m_rv, m_rdk, do_push;
  logic [DW-1:0] m_rd;

  always @(posedge clk) begin
    if (reset) begin
      q_half.delete(); q_cnt.delete();
      mode = 0; wr_idx = 0; fcnt = 0; m_ovf = 0; m_rv = 0; m_rdk = 0;
    end else begin
      n_full  = q_half.size();
      do_push = 0;
      m_rv    = 0;
      if (rd_en && n_full > 0) begin
        m_rv  = 1;
        m_rdk = known[q_half[0]][rd_addr];
        m_rd  = mm[q_half[0]][rd_addr];
      end
      if (in_valid) begin
        if (mode == 0 && in_sos) begin
          if (n_full < 2) begin
            mm[wr_idx][in_addr] = in_data; known[wr_idx][in_addr] = 1;
            fcnt = 1;
            if (in_eos) begin do_push = 1; push_c = 1; end
            else mode = 1;
          end else begin
            m_ovf = 1;
            if (!in_eos) mode = 2;
          end
        end else if (mode == 1) begin
          mm[wr_idx][in_addr] = in_data; known[wr_idx][in_addr] = 1;
          if (in_sos) fcnt = 1;
          else if (fcnt < 64) fcnt++;
          if (in_eos) begin do_push = 1; push_c = fcnt; mode = 0; end
        end else if (mode == 2 && in_eos) begin
          mode = 0;
        end
      end
      if (rd_release && n_full > 0) begin
        void'(q_half.pop_front()); void'(q_cnt.pop_front());
      end
      if (do_push) begin
        q_half.push_back(wr_idx); q_cnt.push_back(push_c); wr_idx ^= 1;
      end
    end
  end

  // Compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    chk("buf_ready", buf_ready, q_half.size() > 0);
    chk("can_accept", can_accept, (mode == 0) && (q_half.size() < 2));
    chk("lines_stored", lines_stored, (q_half.size() > 0) ? q_cnt[0] : 0);
    chk("overflow_err", overflow_err, m_ovf);
    chk("rd_data_valid", rd_data_valid, m_rv);
    if (m_rv && m_rdk) chk("rd_data", rd_data, m_rd);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input bit s, input bit e, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit re, input logic [AW-1:0] ra,
                     input bit rel);
    in_valid = v; in_sos = s; in_eos = e; in_addr = a; in_data = d;
    rd_en = re; rd_addr = ra; rd_release = rel;
    @(negedge clk);
    in_valid = 0; in_sos = 0; in_eos = 0; in_addr = '0; in_data = '0;
    rd_en = 0; rd_addr = '0; rd_release = 0;
  endtask

  task automatic stream(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++)
      cyc(1, i == 0, i == n - 1, AW'(i), base + DW'(i), 0, '0, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    cyc(0, 0, 0, '0, '0, 1, a, 0);
    chk({name, "_valid"}, rd_data_valid, 1'b1);
    chk(name, rd_data, exp);
  endtask

  initial begin
    reset = 1;
    in_valid = 0; in_sos = 0; in_eos = 0; in_addr = '0; in_data = '0;
    rd_en = 0; rd_addr = '0; rd_release = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_can_accept", can_accept, 1'b1);
    chk("rst_buf_ready", buf_ready, 1'b0);
    chk("rst_lines", lines_stored, 0);
    chk("rst_rd_valid", rd_data_valid, 1'b0);

    // 8-line stream, read back A=5
    stream(8, 64'h100);
    chk("t1_ready", buf_ready, 1'b1);
    chk("t1_lines", lines_stored, 8);
    chk("t1_can_accept", can_accept, 1'b1);
    rd(6'd5, 64'h105, "t1_rd5");

    // second stream fills other half; third stream dropped
    stream(8, 64'h200);
    chk("t2_can_accept", can_accept, 1'b0);
    stream(2, 64'h300);
    chk("t2_ovf", overflow_err, 1'b1);
    cyc(0, 0, 0, '0, '0, 0, '0, 1);
    chk("t2_ready_after_rel", buf_ready, 1'b1);
    chk("t2_lines_after_rel", lines_stored, 8);
    rd(6'd3, 64'h203, "t2_rd3");

    // restart mid-stream
    do_reset();
    cyc(1, 1, 0, 6'd0, 64'h400, 0, '0, 0);
    cyc(1, 0, 0, 6'd1, 64'h401, 0, '0, 0);
    cyc(1, 0, 0, 6'd2, 64'h402, 0, '0, 0);
    cyc(1, 0, 0, 6'd3, 64'h403, 0, '0, 0);
    cyc(1, 1, 0, 6'd0, 64'h500, 0, '0, 0);
    cyc(1, 0, 0, 6'd1, 64'h501, 0, '0, 0);
    cyc(1, 0, 1, 6'd2, 64'h502, 0, '0, 0);
    chk("t3_lines", lines_stored, 3);
    chk("t3_ovf", overflow_err, 1'b0);
    rd(6'd2, 64'h502, "t3_rd2");

    // single-line stream
    do_reset();
    cyc(1, 1, 1, 6'd0, 64'hAB, 0, '0, 0);
    chk("t4_ready", buf_ready, 1'b1);
    chk("t4_lines", lines_stored, 1);
    rd(6'd0, 64'hAB, "t4_rd0");

    // rd_en with no ready half; read and release in the same cycle
    do_reset();
    cyc(0, 0, 0, '0, '0, 1, 6'd0, 0);
    chk("t5_rd_noready", rd_data_valid, 1'b0);
    chk("t5_rd_hold", rd_data, 64'h0);
    cyc(1, 1, 1, 6'd0, 64'hCD, 0, '0, 0);
    cyc(0, 0, 0, '0, '0, 1, 6'd0, 1);
    chk("t5_rdrel_valid", rd_data_valid, 1'b1);
    chk("t5_rdrel_data", rd_data, 64'hCD);
    chk("t5_rdrel_ready", buf_ready, 1'b0);

    // release and sos to the freed half in the same cycle: sos dropped
    do_reset();
    cyc(1, 1, 1, 6'd0, 64'h11, 0, '0, 0);
    cyc(1, 1, 1, 6'd0, 64'h22, 0, '0, 0);
    chk("t6_can_accept_full", can_accept, 1'b0);
    cyc(1, 1, 1, 6'd0, 64'h33, 0, '0, 1);
    chk("t6_ovf", overflow_err, 1'b1);
    chk("t6_lines", lines_stored, 1);
    chk("t6_can_accept", can_accept, 1'b1);
    rd(6'd0, 64'h22, "t6_rd0");
    // eos on one half with release of the other in the same cycle
    cyc(1, 1, 0, 6'd0, 64'h44, 0, '0, 0);
    cyc(1, 0, 1, 6'd1, 64'h45, 0, '0, 1);
    chk("t6_eosrel_ready", buf_ready, 1'b1);
    chk("t6_eosrel_lines", lines_stored, 2);
    rd(6'd1, 64'h45, "t6_rd1");

    // reset during a fill of 3 lines
    cyc(1, 1, 0, 6'd0, 64'h60, 0, '0, 0);
    cyc(1, 0, 0, 6'd1, 64'h61, 0, '0, 0);
    cyc(1, 0, 0, 6'd2, 64'h62, 0, '0, 0);
    chk("t7_filling_can_accept", can_accept, 1'b0);
    do_reset();
    chk("t7_can_accept", can_accept, 1'b1);
    chk("t7_ready", buf_ready, 1'b0);
    chk("t7_ovf", overflow_err, 1'b0);
    chk("t7_lines", lines_stored, 0);

    // count saturates at 2**ADDR_W
    stream(70, 64'h0);
    chk("t8_lines_sat", lines_stored, 64);
    rd(6'd5, 64'd69, "t8_rd5");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
